// File: rtl/bcd_updown_counter_n_pkg.sv
// bcd_pkg: shared BCD constants, command encoding and digit helpers.
// Used by the counter, its digit cell and neighbouring display/control blocks.
// Ports: none (package).
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // One-hot command set {inc, dec, set9, set0}, encoded for the digit cells.
  localparam logic [1:0] CMD_INC  = 2'd0;
  localparam logic [1:0] CMD_DEC  = 2'd1;
  localparam logic [1:0] CMD_SET9 = 2'd2;
  localparam logic [1:0] CMD_SET0 = 2'd3;

  // True when a nibble is a legal decimal digit.
  function automatic logic bcd_is_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

  // Non-BCD nibbles (A..F) are pinned to 9 so the register can never hold them.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    logic [3:0] r;
    if (bcd_is_valid(d)) begin
      r = d;
    end else begin
      r = BCD_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_n_digit_cell.sv
// bcd_digit_cell: combinational next-state of one decimal digit.
// Ports:
//   digit_i  current digit (0..9)
//   ci_i     carry in  (increment this digit)
//   bi_i     borrow in (decrement this digit)
//   cmd_i    command code from bcd_pkg
//   digit_o  next digit
//   co_o     carry out  (digit wrapped 9 -> 0 on increment)
//   bo_o     borrow out (digit wrapped 0 -> 9 on decrement)
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       ci_i,
  input  logic       bi_i,
  input  logic [1:0] cmd_i,
  output logic [3:0] digit_o,
  output logic       co_o,
  output logic       bo_o
);

  // Per-digit increment/decrement/force with ripple carry and borrow.
  always_comb begin
    digit_o = digit_i;
    co_o    = 1'b0;
    bo_o    = 1'b0;
    case (cmd_i)
      CMD_INC: begin
        if (!ci_i) begin
          digit_o = digit_i;
        end else if (digit_i >= BCD_MAX) begin
          digit_o = BCD_ZERO;
          co_o    = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end
      CMD_DEC: begin
        if (!bi_i) begin
          digit_o = digit_i;
        end else if (digit_i == BCD_ZERO) begin
          digit_o = BCD_MAX;
          bo_o    = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
      CMD_SET9: digit_o = BCD_MAX;
      CMD_SET0: digit_o = BCD_ZERO;
      default:  digit_o = digit_i;
    endcase
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n: NDIGITS-digit BCD up/down counter with parallel load,
// wrap or saturate at the boundaries, and one-cycle carry/borrow/load-error pulses.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   inc, dec          count up / down by one
//   set9, set0        force all digits to 9 / 0
//   load, load_val    parallel load (highest priority); digit 0 in load_val[3:0]
//   value             registered count, digit 0 least significant
//   cout, bout        pulse: increment from all-9s / decrement from all-0s
//   load_err          pulse: load_val held a non-BCD digit (loaded as 9)
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int NDIGITS  = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 set9,
  input  logic                 set0,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] load_val,
  output logic [4*NDIGITS-1:0] value,
  output logic                 cout,
  output logic                 bout,
  output logic                 load_err
);

  localparam int W = 4 * NDIGITS;

  logic [W-1:0]     value_q, value_d;
  logic             cout_q, cout_d;
  logic             bout_q, bout_d;
  logic             load_err_q, load_err_d;

  logic [2:0]       n_act_s;
  logic             one_cmd_s;
  logic [1:0]       cmd_s;
  logic [W-1:0]     next_s;
  logic [NDIGITS:0] carry_s;
  logic [NDIGITS:0] borrow_s;
  logic [W-1:0]     load_clamped_s;
  logic             load_bad_s;

  // Exactly one of the four commands must be active for it to take effect.
  always_comb begin
    n_act_s   = {2'b00, inc} + {2'b00, dec} + {2'b00, set9} + {2'b00, set0};
    one_cmd_s = (n_act_s == 3'd1);
    if (inc) begin
      cmd_s = CMD_INC;
    end else if (dec) begin
      cmd_s = CMD_DEC;
    end else if (set9) begin
      cmd_s = CMD_SET9;
    end else begin
      cmd_s = CMD_SET0;
    end
  end

  // Digit 0 always receives the carry/borrow; the cells ripple it upward.
  assign carry_s[0]  = 1'b1;
  assign borrow_s[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < NDIGITS; g++) begin : g_digit
      bcd_digit_cell u_cell (
        .digit_i (value_q[4*g +: 4]),
        .ci_i    (carry_s[g]),
        .bi_i    (borrow_s[g]),
        .cmd_i   (cmd_s),
        .digit_o (next_s[4*g +: 4]),
        .co_o    (carry_s[g+1]),
        .bo_o    (borrow_s[g+1])
      );
    end
  endgenerate

  // Clamp each load digit into 0..9 and flag any that needed clamping.
  always_comb begin
    load_clamped_s = '0;
    load_bad_s     = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      load_clamped_s[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
      if (!bcd_is_valid(load_val[4*i +: 4])) begin
        load_bad_s = 1'b1;
      end else begin
        load_bad_s = load_bad_s;
      end
    end
  end

  // Next-state selection: load, then a single command, otherwise hold.
  // A carry/borrow out of the top digit means the counter sat at all-9s/all-0s.
  always_comb begin
    value_d    = value_q;
    cout_d     = 1'b0;
    bout_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      value_d    = load_clamped_s;
      load_err_d = load_bad_s;
    end else if (one_cmd_s) begin
      case (cmd_s)
        CMD_INC: begin
          cout_d = carry_s[NDIGITS];
          if (SATURATE && carry_s[NDIGITS]) begin
            value_d = value_q;
          end else begin
            value_d = next_s;
          end
        end
        CMD_DEC: begin
          bout_d = borrow_s[NDIGITS];
          if (SATURATE && borrow_s[NDIGITS]) begin
            value_d = value_q;
          end else begin
            value_d = next_s;
          end
        end
        CMD_SET9: value_d = next_s;
        CMD_SET0: value_d = next_s;
        default:  value_d = value_q;
      endcase
    end else begin
      value_d = value_q;
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q    <= '0;
      cout_q     <= 1'b0;
      bout_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      cout_q     <= cout_d;
      bout_q     <= bout_d;
      load_err_q <= load_err_d;
    end
  end

  assign value    = value_q;
  assign cout     = cout_q;
  assign bout     = bout_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench for bcd_updown_counter_n: three instances
// (2 digits wrap, 2 digits saturate, 4 digits wrap) driven one at a time.
module tb_bcd_updown_counter_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  inc_v = '0, dec_v = '0, s9_v = '0, s0_v = '0, ld_v = '0;
  logic [7:0]  lv0 = '0, lv1 = '0;
  logic [15:0] lv2 = '0;
  logic [7:0]  val0, val1;
  logic [15:0] val2;
  logic [2:0]  co_v, bo_v, le_v;

  bcd_updown_counter_n #(.NDIGITS(2), .SATURATE(1'b0)) u_wrap2 (
    .clk(clk), .rst_n(rst_n), .inc(inc_v[0]), .dec(dec_v[0]), .set9(s9_v[0]),
    .set0(s0_v[0]), .load(ld_v[0]), .load_val(lv0), .value(val0),
    .cout(co_v[0]), .bout(bo_v[0]), .load_err(le_v[0]));

  bcd_updown_counter_n #(.NDIGITS(2), .SATURATE(1'b1)) u_sat2 (
    .clk(clk), .rst_n(rst_n), .inc(inc_v[1]), .dec(dec_v[1]), .set9(s9_v[1]),
    .set0(s0_v[1]), .load(ld_v[1]), .load_val(lv1), .value(val1),
    .cout(co_v[1]), .bout(bo_v[1]), .load_err(le_v[1]));

  bcd_updown_counter_n #(.NDIGITS(4), .SATURATE(1'b0)) u_wrap4 (
    .clk(clk), .rst_n(rst_n), .inc(inc_v[2]), .dec(dec_v[2]), .set9(s9_v[2]),
    .set0(s0_v[2]), .load(ld_v[2]), .load_val(lv2), .value(val2),
    .cout(co_v[2]), .bout(bo_v[2]), .load_err(le_v[2]));

  typedef struct {
    int          inst;
    int          due;
    logic [15:0] v;
    logic        c;
    logic        b;
    logic        e;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] actual(input int inst);
    logic [18:0] r;
    case (inst)
      0:       r = {8'h00, val0, co_v[0], bo_v[0], le_v[0]};
      1:       r = {8'h00, val1, co_v[1], bo_v[1], le_v[1]};
      default: r = {val2, co_v[2], bo_v[2], le_v[2]};
    endcase
    return r;
  endfunction

  task automatic compare(input int inst, input logic [15:0] v, input logic c,
                         input logic b, input logic e, input string name);
    logic [18:0] act;
    act = actual(inst);
    n_chk++;
    if (act !== {v, c, b, e}) begin
      n_err++;
      $display("FAIL %s (dut%0d): got value=%h cout=%b bout=%b load_err=%b, want value=%h cout=%b bout=%b load_err=%b",
               name, inst, act[18:3], act[2], act[1], act[0], v, c, b, e);
    end
  endtask

  // Monitor: each registered output is compared once the edge that produced it has passed.
  always @(negedge clk) begin : monitor
    exp_t x;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      x = sb.pop_front();
      compare(x.inst, x.v, x.c, x.b, x.e, x.name);
    end
  end

  task automatic clear_inputs();
    inc_v = '0; dec_v = '0; s9_v = '0; s0_v = '0; ld_v = '0;
    lv0 = '0; lv1 = '0; lv2 = '0;
  endtask

  // Drive one cycle of stimulus to one instance and queue its expected response.
  task automatic cmd(input int inst, input logic i, input logic d, input logic s9,
                     input logic s0, input logic ld, input logic [15:0] lv,
                     input logic [15:0] ev, input logic ec, input logic eb,
                     input logic ee, input string name);
    exp_t x;
    @(negedge clk);
    clear_inputs();
    inc_v[inst] = i; dec_v[inst] = d; s9_v[inst] = s9; s0_v[inst] = s0; ld_v[inst] = ld;
    case (inst)
      0:       lv0 = lv[7:0];
      1:       lv1 = lv[7:0];
      default: lv2 = lv;
    endcase
    x.inst = inst; x.due = cyc + 1; x.v = ev; x.c = ec; x.b = eb; x.e = ee; x.name = name;
    sb.push_back(x);
  endtask

  task automatic t_load(input int inst, input logic [15:0] lv, input logic [15:0] ev,
                        input logic ee, input string name);
    cmd(inst, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lv, ev, 1'b0, 1'b0, ee, name);
  endtask
  task automatic t_inc(input int inst, input logic [15:0] ev, input logic ec, input string name);
    cmd(inst, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, ev, ec, 1'b0, 1'b0, name);
  endtask
  task automatic t_dec(input int inst, input logic [15:0] ev, input logic eb, input string name);
    cmd(inst, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, ev, 1'b0, eb, 1'b0, name);
  endtask
  task automatic t_idle(input int inst, input logic [15:0] ev, input string name);
    cmd(inst, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, ev, 1'b0, 1'b0, 1'b0, name);
  endtask

  // Release stimulus and wait (bounded) until every expectation has been checked.
  task automatic drain();
    int n;
    @(negedge clk);
    clear_inputs();
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_err++;
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending expectations, want 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [15:0] to_bcd(input int m);
    return {4'(m / 1000 % 10), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
  endfunction

  int  model;
  bit  up;
  logic ec, eb;

  initial begin
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    compare(0, 16'h0000, 1'b0, 1'b0, 1'b0, "reset_wrap2");
    compare(1, 16'h0000, 1'b0, 1'b0, 1'b0, "reset_sat2");
    compare(2, 16'h0000, 1'b0, 1'b0, 1'b0, "reset_wrap4");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-count.
    t_load(0, 16'h0037, 16'h0037, 1'b0, "load_37");
    drain();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 compare(0, 16'h0000, 1'b0, 1'b0, 1'b0, "async_reset_37");
    @(negedge clk);
    rst_n = 1'b1;

    // Set commands, 2 digits wrapping.
    cmd(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0099, 1'b0, 1'b0, 1'b0, "set9");
    t_idle(0, 16'h0099, "hold_after_set9");
    cmd(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0, "set0");

    // Cascade increment with wrap.
    t_load(0, 16'h0098, 16'h0098, 1'b0, "load_98");
    t_inc(0, 16'h0099, 1'b0, "inc_98_99");
    t_inc(0, 16'h0000, 1'b1, "inc_99_wrap");
    t_idle(0, 16'h0000, "cout_one_cycle");
    t_inc(0, 16'h0001, 1'b0, "inc_00_01");

    // Cascade decrement with borrow.
    t_load(0, 16'h0010, 16'h0010, 1'b0, "load_10");
    t_dec(0, 16'h0009, 1'b0, "dec_10_09");
    t_load(0, 16'h0000, 16'h0000, 1'b0, "load_00");
    t_dec(0, 16'h0099, 1'b1, "dec_00_wrap");
    t_idle(0, 16'h0099, "bout_one_cycle");

    // Conflicts and load priority.
    t_load(0, 16'h0042, 16'h0042, 1'b0, "load_42");
    cmd(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0042, 1'b0, 1'b0, 1'b0, "inc_dec_conflict");
    cmd(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0042, 1'b0, 1'b0, 1'b0, "set9_set0_conflict");
    cmd(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0057, 16'h0057, 1'b0, 1'b0, 1'b0, "load_over_inc");
    t_load(0, 16'h003C, 16'h0039, 1'b1, "load_nonbcd_3C");
    t_idle(0, 16'h0039, "load_err_one_cycle");
    drain();

    // Saturating instance.
    cmd(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0099, 1'b0, 1'b0, 1'b0, "sat_set9");
    t_inc(1, 16'h0099, 1'b1, "sat_inc_ceiling");
    t_idle(1, 16'h0099, "sat_hold");
    cmd(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0, "sat_set0");
    t_dec(1, 16'h0000, 1'b1, "sat_dec_floor");
    t_inc(1, 16'h0001, 1'b0, "sat_inc_00_01");
    t_dec(1, 16'h0000, 1'b0, "sat_dec_01_00");
    drain();

    // Four-digit scaling.
    t_load(2, 16'h0999, 16'h0999, 1'b0, "w4_load_0999");
    t_inc(2, 16'h1000, 1'b0, "w4_inc_1000");
    t_load(2, 16'hA0F5, 16'h9095, 1'b1, "w4_load_nonbcd");
    t_load(2, 16'h9999, 16'h9999, 1'b0, "w4_load_9999");
    t_inc(2, 16'h0000, 1'b1, "w4_inc_wrap");
    t_dec(2, 16'h9999, 1'b1, "w4_dec_wrap");

    // Random inc/dec walk against a modulo-10000 model, starting at 9999.
    model = 9999;
    for (int k = 0; k < 40; k++) begin
      up = 1'($urandom_range(0, 1));
      ec = 1'b0;
      eb = 1'b0;
      if (up) begin
        if (model == 9999) begin
          model = 0;
          ec = 1'b1;
        end else begin
          model = model + 1;
        end
        t_inc(2, to_bcd(model), ec, "w4_rand_inc");
      end else begin
        if (model == 0) begin
          model = 9999;
          eb = 1'b1;
        end else begin
          model = model - 1;
        end
        t_dec(2, to_bcd(model), eb, "w4_rand_dec");
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
